// File: rtl/dbus_access_ctrl.sv
// dbus_access_ctrl: sequences MEM-stage loads/stores onto the data bus with addr_ok/data_ok handshake,
// forming byte strobes/lane data on the way out and extending load data on the way back.
module dbus_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mem_valid,
  input  logic          mem_write,
  input  logic [1:0]    mem_size,
  input  logic          mem_unsigned,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          pipe_ready,
  output logic          mem_stall,
  output logic          mem_done,
  output logic [DW-1:0] mem_rdata,
  output logic          addr_err,
  output logic          dreq_valid,
  output logic [AW-1:0] dreq_addr,
  output logic [1:0]    dreq_size,
  output logic [3:0]    dreq_strobe,
  output logic [DW-1:0] dreq_data,
  input  logic          dresp_addr_ok,
  input  logic          dresp_data_ok,
  input  logic [DW-1:0] dresp_data
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic          write_q, unsigned_q;
  logic [1:0]    off_q;
  logic          misaligned, accept, capture;
  logic [3:0]    strobe_nx;
  logic [DW-1:0] data_nx, rdata_nx;
  logic [15:0]   half_v;
  logic [7:0]    byte_v;
  always_comb begin
    misaligned = (mem_size == 2'b00 && mem_addr[1:0] != 2'b00) || (mem_size == 2'b01 && mem_addr[0]);
    accept     = state == IDLE && mem_valid && !misaligned;
    addr_err   = state == IDLE && mem_valid && misaligned;
    mem_stall  = accept || state == REQ || state == WAIT;
    dreq_valid = state == REQ;
    capture    = dresp_data_ok && ((state == REQ && dresp_addr_ok) || state == WAIT);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = accept ? REQ : IDLE;
      REQ:  state_nx = dresp_addr_ok ? (dresp_data_ok ? DONE : WAIT) : REQ;
      WAIT: state_nx = dresp_data_ok ? DONE : WAIT;
      DONE: state_nx = pipe_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    strobe_nx = mem_size == 2'b00 ? 4'b1111 :
                mem_size == 2'b01 ? (mem_addr[1] ? 4'b1100 : 4'b0011) :
                4'b0001 << mem_addr[1:0];
    strobe_nx = mem_write ? strobe_nx : 4'b0000;
    data_nx   = mem_size == 2'b00 ? mem_wdata :
                mem_size == 2'b01 ? (mem_addr[1] ? {mem_wdata[15:0], 16'b0} : {16'b0, mem_wdata[15:0]}) :
                {24'b0, mem_wdata[7:0]} << {mem_addr[1:0], 3'b000};
  end
  // Extraction uses the latched size/offset, not the live MEM-stage inputs.
  always_comb begin
    half_v   = off_q[1] ? dresp_data[31:16] : dresp_data[15:0];
    byte_v   = 8'(dresp_data >> {off_q, 3'b000});
    rdata_nx = write_q ? '0 :
               dreq_size == 2'b00 ? dresp_data :
               dreq_size == 2'b01 ? {{16{~unsigned_q & half_v[15]}}, half_v} :
               {{24{~unsigned_q & byte_v[7]}}, byte_v};
  end
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      off_q       <= 2'b00;
      dreq_addr   <= '0;
      dreq_size   <= 2'b00;
      dreq_strobe <= 4'b0000;
      dreq_data   <= '0;
      mem_rdata   <= '0;
      mem_done    <= 1'b0;
    end else begin
      if (accept) begin
        write_q     <= mem_write;
        unsigned_q  <= mem_unsigned;
        off_q       <= mem_addr[1:0];
        dreq_addr   <= {mem_addr[AW-1:2], 2'b00};
        dreq_size   <= mem_size;
        dreq_strobe <= strobe_nx;
        dreq_data   <= data_nx;
      end
      if (capture) begin
        mem_rdata <= rdata_nx;
        mem_done  <= 1'b1;
      end else if (state == DONE && pipe_ready) begin
        mem_rdata <= '0;
        mem_done  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dbus_access_ctrl.sv
// tb_dbus_access_ctrl: directed-vector bench for dbus_access_ctrl with hand-computed expectations.
module tb_dbus_access_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0, pipe_ready = 1'b1;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_stall, mem_done, addr_err, dreq_valid;
  logic [31:0] mem_rdata, dreq_addr, dreq_data;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  int n_cmp = 0, n_err = 0;

  dbus_access_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pipe_ready(pipe_ready), .mem_stall(mem_stall),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .addr_err(addr_err),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic full_txn(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strobe,
                          input logic [31:0] exp_data, input logic [31:0] exp_rdata);
    mem_valid = 1'b1; mem_write = w; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wd; pipe_ready = 1'b1;
    #1;
    chk({tag, " accept stall"}, 32'(mem_stall), 32'd1);
    chk({tag, " accept addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, " accept dreq_valid"}, 32'(dreq_valid), 32'd0);
    tick;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = rd;
    #1;
    chk({tag, " req valid"}, 32'(dreq_valid), 32'd1);
    chk({tag, " req stall"}, 32'(mem_stall), 32'd1);
    chk({tag, " req addr"}, dreq_addr, exp_addr);
    chk({tag, " req strobe"}, 32'(dreq_strobe), 32'(exp_strobe));
    chk({tag, " req size"}, 32'(dreq_size), 32'(sz));
    if (w) chk({tag, " req data"}, dreq_data, exp_data);
    tick;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; mem_valid = 1'b0;
    #1;
    chk({tag, " done"}, 32'(mem_done), 32'd1);
    chk({tag, " done stall"}, 32'(mem_stall), 32'd0);
    chk({tag, " rdata"}, mem_rdata, exp_rdata);
    tick;
    chk({tag, " idle done"}, 32'(mem_done), 32'd0);
    chk({tag, " idle rdata"}, mem_rdata, 32'd0);
    chk({tag, " idle valid"}, 32'(dreq_valid), 32'd0);
  endtask

  initial begin
    tick; tick;
    resetn = 1'b1;
    #1;
    chk("rst stall", 32'(mem_stall), 32'd0);
    chk("rst done", 32'(mem_done), 32'd0);
    chk("rst valid", 32'(dreq_valid), 32'd0);
    chk("rst addr", dreq_addr, 32'd0);
    chk("rst rdata", mem_rdata, 32'd0);
    chk("rst addr_err", 32'(addr_err), 32'd0);

    full_txn("lw", 1'b0, 2'b00, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF,
             32'h1000_0004, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    full_txn("sb", 1'b1, 2'b10, 1'b0, 32'h2000_0003, 32'h0000_00A5, 32'h1111_1111,
             32'h2000_0000, 4'b1000, 32'hA500_0000, 32'h0);
    full_txn("lh_s", 1'b0, 2'b01, 1'b0, 32'h3000_0002, 32'h0, 32'h8001_1234,
             32'h3000_0000, 4'b0000, 32'h0, 32'hFFFF_8001);
    full_txn("lhu", 1'b0, 2'b01, 1'b1, 32'h3000_0002, 32'h0, 32'h8001_1234,
             32'h3000_0000, 4'b0000, 32'h0, 32'h0000_8001);
    full_txn("sh_lo", 1'b1, 2'b01, 1'b0, 32'h3000_0010, 32'hAAAA_5555, 32'h0,
             32'h3000_0010, 4'b0011, 32'h0000_5555, 32'h0);
    full_txn("sh_hi", 1'b1, 2'b01, 1'b0, 32'h3000_0012, 32'hAAAA_5555, 32'h0,
             32'h3000_0010, 4'b1100, 32'h5555_0000, 32'h0);
    full_txn("lbu", 1'b0, 2'b11, 1'b1, 32'h3000_0023, 32'h0, 32'h9A00_0000,
             32'h3000_0020, 4'b0000, 32'h0, 32'h0000_009A);
    full_txn("sw", 1'b1, 2'b00, 1'b0, 32'h3000_0040, 32'hCAFE_F00D, 32'h0,
             32'h3000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // split handshake: LB at offset 1, addr_ok after 3 stalled REQ cycles
    mem_valid = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    mem_addr = 32'h4000_0001; pipe_ready = 1'b1;
    #1;
    chk("split accept stall", 32'(mem_stall), 32'd1);
    tick;
    for (int i = 0; i < 3; i++) begin
      dresp_addr_ok = 1'b0; dresp_data_ok = (i == 1); dresp_data = 32'h1234_F0AB;
      #1;
      chk("split req valid", 32'(dreq_valid), 32'd1);
      chk("split req addr", dreq_addr, 32'h4000_0000);
      chk("split req size", 32'(dreq_size), 32'd2);
      chk("split req stall", 32'(mem_stall), 32'd1);
      tick;
    end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
    #1;
    chk("split req4 valid", 32'(dreq_valid), 32'd1);
    chk("split req4 addr", dreq_addr, 32'h4000_0000);
    tick;
    dresp_addr_ok = 1'b0;
    #1;
    chk("split wait1 valid", 32'(dreq_valid), 32'd0);
    chk("split wait1 stall", 32'(mem_stall), 32'd1);
    chk("split wait1 done", 32'(mem_done), 32'd0);
    tick;
    dresp_data_ok = 1'b1;
    #1;
    chk("split wait2 valid", 32'(dreq_valid), 32'd0);
    chk("split wait2 stall", 32'(mem_stall), 32'd1);
    tick;
    dresp_data_ok = 1'b0; pipe_ready = 1'b0;
    #1;
    chk("split done", 32'(mem_done), 32'd1);
    chk("split rdata", mem_rdata, 32'hFFFF_FFF0);
    chk("split done stall", 32'(mem_stall), 32'd0);
    tick;
    dresp_data_ok = 1'b1; dresp_addr_ok = 1'b1; dresp_data = 32'h0;
    #1;
    chk("hold done", 32'(mem_done), 32'd1);
    chk("hold rdata", mem_rdata, 32'hFFFF_FFF0);
    chk("hold valid", 32'(dreq_valid), 32'd0);
    chk("hold stall", 32'(mem_stall), 32'd0);
    tick;
    dresp_data_ok = 1'b0; dresp_addr_ok = 1'b0;
    #1;
    chk("hold2 rdata", mem_rdata, 32'hFFFF_FFF0);
    pipe_ready = 1'b1; mem_valid = 1'b0;
    tick;
    chk("split idle done", 32'(mem_done), 32'd0);
    chk("split idle rdata", mem_rdata, 32'd0);

    // misaligned accesses
    mem_valid = 1'b1; mem_write = 1'b1; mem_size = 2'b00; mem_addr = 32'h5000_0002;
    #1;
    chk("sw mis addr_err", 32'(addr_err), 32'd1);
    chk("sw mis stall", 32'(mem_stall), 32'd0);
    tick;
    chk("sw mis valid", 32'(dreq_valid), 32'd0);
    chk("sw mis addr_err2", 32'(addr_err), 32'd1);
    mem_write = 1'b0; mem_size = 2'b01; mem_addr = 32'h5000_0001;
    #1;
    chk("lh mis addr_err", 32'(addr_err), 32'd1);
    tick;
    chk("lh mis valid", 32'(dreq_valid), 32'd0);
    mem_valid = 1'b0;
    #1;
    chk("mis clear addr_err", 32'(addr_err), 32'd0);

    // reset while in WAIT
    mem_valid = 1'b1; mem_write = 1'b0; mem_size = 2'b00; mem_addr = 32'h6000_0000;
    tick;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b0;
    tick;
    dresp_addr_ok = 1'b0; resetn = 1'b0;
    #1;
    chk("wait stall", 32'(mem_stall), 32'd1);
    tick;
    resetn = 1'b1; mem_valid = 1'b0;
    #1;
    chk("rst2 stall", 32'(mem_stall), 32'd0);
    chk("rst2 valid", 32'(dreq_valid), 32'd0);
    chk("rst2 addr", dreq_addr, 32'd0);
    chk("rst2 size", 32'(dreq_size), 32'd0);
    chk("rst2 done", 32'(mem_done), 32'd0);
    dresp_data_ok = 1'b1; dresp_data = 32'h7777_7777;
    tick;
    dresp_data_ok = 1'b0;
    #1;
    chk("stray done", 32'(mem_done), 32'd0);
    chk("stray rdata", mem_rdata, 32'd0);
    chk("stray stall", 32'(mem_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dbus_access_ctrl.md
Name: dbus_access_ctrl

Overview:
- Sequences every load/store from the MEM stage onto the data bus.
- Computes byte strobes and lane-aligned write data, and runs the addr_ok/data_ok handshake.
- Stalls the pipeline while a request is outstanding, and returns sign/zero-extended load data.
- Sits between the MEM stage and the dbus port of the core.

Parameters:
- AW, 32, address width (dreq_addr, mem_addr)
- DW, 32, data width; only 32 is supported

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  MEM stage holds a memory instruction
- mem_write  in  1  1 = store, 0 = load
- mem_size  in  2  00 word, 01 half, 10/11 byte
- mem_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_addr  in  AW  effective byte address
- mem_wdata  in  DW  store data, right-justified
- pipe_ready  in  1  downstream accepts the MEM result this cycle
- mem_stall  out  1  freeze IF..MEM this cycle
- mem_done  out  1  access complete; mem_rdata valid
- mem_rdata  out  DW  extended load data (0 for stores)
- addr_err  out  1  misaligned access detected (AdEL/AdES)
- dreq_valid  out  1  bus request valid
- dreq_addr  out  AW  word-aligned request address
- dreq_size  out  2  copy of latched mem_size
- dreq_strobe  out  4  byte write enables; 0000 for loads
- dreq_data  out  DW  lane-aligned write data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  data phase complete
- dresp_data  in  DW  raw read word

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (resetn=0 at posedge) values:
  - State goes to IDLE.
  - All registered outputs (dreq_*, mem_rdata, mem_done) are 0.
  - mem_stall=0, addr_err=0.
  - Reset mid-transaction abandons it; no response is awaited afterwards.
- Misalignment (combinational, IDLE only):
  - Misaligned when size=00 and addr[1:0]!=0, or size=01 and addr[0]!=0.
  - addr_err=mem_valid&misaligned.
  - No request is issued, no stall, and the state stays IDLE.
- IDLE:
  - Accept when mem_valid&!misaligned.
  - On accept, latch write, size, unsigned, addr[1:0], dreq_addr={addr[AW-1:2],2'b00}, dreq_strobe and dreq_data; next state REQ.
  - mem_stall=1 in the accept cycle.
- Strobe/data formation:
  - word: strobe=1111, data unchanged.
  - half: addr[1]=0 gives 0011 with data {16'b0,wd[15:0]}; addr[1]=1 gives 1100 with data {wd[15:0],16'b0}.
  - byte: strobe=0001<<addr[1:0], data=wd[7:0] shifted by 8*addr[1:0], other lanes 0.
  - Strobe is 0000 for loads.
- REQ:
  - dreq_valid=1; addr, size, strobe and data are held stable until addr_ok. mem_stall=1.
  - addr_ok&data_ok in the same cycle → DONE.
  - addr_ok alone → WAIT.
  - data_ok without addr_ok is ignored.
- WAIT:
  - dreq_valid=0, mem_stall=1.
  - data_ok → DONE, capturing the extracted read data.
- Load extraction from dresp_data by latched addr[1:0]:
  - word: passthrough.
  - half: lane by addr[1], sign-extend bit 15 unless unsigned.
  - byte: lane by addr[1:0], sign-extend bit 7 unless unsigned.
- DONE:
  - mem_done=1, mem_stall=0, mem_rdata held.
  - pipe_ready=1 → IDLE next cycle, with mem_done and mem_rdata cleared.
  - pipe_ready=0 → stay in DONE with outputs held, and mem_valid is not re-accepted.
- Latency, load or store:
  - Minimum 2 cycles of stall (accept cycle plus a REQ cycle with addr_ok&data_ok).
  - mem_done occurs in the following cycle.
- Stray data_ok/addr_ok in IDLE or DONE is ignored.
- Only one transaction is ever outstanding.

Test Plan:
- LW at 0x1000_0004, addr_ok&data_ok in the first REQ cycle, dresp_data=0xDEADBEEF, pipe_ready=1
  → stall for 2 cycles, dreq_strobe=0000, mem_done next cycle, mem_rdata=0xDEADBEEF, IDLE after.
- SB at 0x...03 with wdata=0x000000A5
  → dreq_strobe=1000, dreq_data=0xA5000000, dreq_addr=0x...00.
- LH at 0x...02 with dresp_data=0x8001_1234, signed then unsigned
  → mem_rdata=0xFFFF8001 (signed), 0x00008001 (unsigned).
- Split handshake: addr_ok held low 3 cycles, then addr_ok, data_ok 2 cycles later
  → dreq_valid high for exactly 4 cycles with stable fields, stall throughout, mem_done one cycle after data_ok.
- SW at 0x...02
  → addr_err=1 the same cycle, dreq_valid never asserts, mem_stall=0.
- Edge cases:
  - resetn=0 while in WAIT → next cycle IDLE with all outputs 0, and a subsequent data_ok is ignored.
  - pipe_ready=0 in DONE → mem_done and mem_rdata held until pipe_ready=1.
